// File: rtl/uart_fifo_drain_ctrl_pkg.sv
// Shared types for the UART TX FIFO drain sequencer.
// State encoding and the shared down-counter helpers.
package uart_fifo_drain_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned SENT_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POP       = 3'd1,
    S_CAPTURE   = 3'd2,
    S_START     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_GAP       = 3'd6
  } state_t;

  // True on the final cycle of a count loaded with N (N cycles total).
  function automatic logic cnt_last(
    input logic [CNT_W-1:0] cnt
  );
    return (cnt <= CNT_W'(1));
  endfunction

endpackage

// File: rtl/uart_fifo_drain_ctrl.sv
// Pops bytes from the TX FIFO and hands them to uart_tx one frame at a time.
// Moore FSM; gap and busy-timeout share one down-counter.
module uart_fifo_drain_ctrl
  import uart_fifo_drain_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned BUSY_TO    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic [SENT_W-1:0] bytes_sent,
  output logic              tx_err,
  output logic              ctrl_busy
);

  localparam logic             HAS_GAP = (GAP_CYCLES != 0);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] BUSY_LD = CNT_W'(BUSY_TO);
  localparam state_t           END_ST  = HAS_GAP ? S_GAP : S_IDLE;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             go;

  assign go = enable && !fifo_empty && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      fifo_rd_en <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      bytes_sent <= '0;
      tx_err     <= 1'b0;
      ctrl_busy  <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      tx_start   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go) begin
            state      <= S_POP;
            fifo_rd_en <= 1'b1;
            ctrl_busy  <= 1'b1;
          end
        end
        S_POP: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          tx_data  <= fifo_data;
          tx_start <= 1'b1;
          state    <= S_START;
        end
        S_START: begin
          bytes_sent <= bytes_sent + 1'b1;
          cnt        <= BUSY_LD;
          state      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (cnt_last(cnt)) begin
            // TX never acknowledged; flag it and move on.
            tx_err    <= 1'b1;
            state     <= END_ST;
            cnt       <= GAP_LD;
            ctrl_busy <= HAS_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            state     <= END_ST;
            cnt       <= GAP_LD;
            ctrl_busy <= HAS_GAP;
          end
        end
        S_GAP: begin
          if (cnt_last(cnt)) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ctrl_busy <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          ctrl_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
